// File: rtl/gf180mcu_clkdiv_pkg.sv
// Shared types for the programmable glitch-free clock divider.
// FSM state encoding and the default ratio-code width.
package gf180mcu_clkdiv_pkg;

    localparam int DIV_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HI   = 2'd1,
        LO   = 2'd2
    } state_t;

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__clkdiv_phase.sv
// Maps the active ratio code to high/low phase lengths.
// GF180MCU_CLKDIV_ODD_EN selects N=ACT+2 split ceil/floor; otherwise H=L=ACT+1.
module gf180mcu_fd_sc_mcu7t5v0__clkdiv_phase
    import gf180mcu_clkdiv_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic [DIV_W-1:0] act,
    output logic [DIV_W:0]   h,
    output logic [DIV_W:0]   l
);

`ifdef GF180MCU_CLKDIV_ODD_EN
    logic [DIV_W+1:0] n;

    assign n = {2'b00, act} + (DIV_W+2)'(2);
    // Odd ratios put the extra cycle in the high phase.
    assign h = (DIV_W+1)'((n + (DIV_W+2)'(1)) >> 1);
    assign l = (DIV_W+1)'(n >> 1);
`else
    assign h = {1'b0, act} + (DIV_W+1)'(1);
    assign l = h;
`endif

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__clkdiv_prog.sv
// Programmable integer clock divider with registered, runt-free output Z.
// Ratio reloads and enable changes land only on period boundaries (GF180MCU_CLKDIV_ODD_EN).
module gf180mcu_fd_sc_mcu7t5v0__clkdiv_prog
    import gf180mcu_clkdiv_pkg::*;
#(
    parameter int               DIV_W   = DIV_W_DEF,
    parameter logic [DIV_W-1:0] DIV_RST = '0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             LOAD,
    input  logic [DIV_W-1:0] DIV,
    output logic             Z,
    output logic             BUSY,
    inout  wire              VDD,
    inout  wire              VSS
);

    state_t           state_q, state_d;
    logic [DIV_W:0]   cnt_q, cnt_d;
    logic [DIV_W-1:0] act_q, act_d;
    logic [DIV_W-1:0] pend_q, pend_d;
    logic             pend_v_q, pend_v_d;
    logic             z_q, z_d;
    logic             apply;
    logic [DIV_W:0]   h, l;
    logic             last_hi, last_lo;
    logic             unused_supply;

    assign unused_supply = VDD ^ VSS;

    gf180mcu_fd_sc_mcu7t5v0__clkdiv_phase #(
        .DIV_W (DIV_W)
    ) u_phase (
        .act (act_q),
        .h   (h),
        .l   (l)
    );

    assign last_hi = (cnt_q == h - (DIV_W+1)'(1));
    assign last_lo = (cnt_q == l - (DIV_W+1)'(1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        z_d     = z_q;
        apply   = 1'b0;
        unique case (state_q)
            IDLE: begin
                z_d   = 1'b0;
                cnt_d = '0;
                if (EN) begin
                    state_d = HI;
                    z_d     = 1'b1;
                    apply   = pend_v_q;
                end
            end
            HI: begin
                z_d = 1'b1;
                if (last_hi) begin
                    state_d = LO;
                    z_d     = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + (DIV_W+1)'(1);
                end
            end
            LO: begin
                z_d = 1'b0;
                if (last_lo) begin
                    cnt_d = '0;
                    if (EN) begin
                        state_d = HI;
                        z_d     = 1'b1;
                        apply   = pend_v_q;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + (DIV_W+1)'(1);
                end
            end
            default: begin
                state_d = IDLE;
                z_d     = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    // An apply consumes the old PEND; a same-cycle LOAD stays pending.
    always_comb begin
        act_d    = apply ? pend_q : act_q;
        pend_d   = LOAD ? DIV : pend_q;
        pend_v_d = pend_v_q;
        if (LOAD) begin
            pend_v_d = 1'b1;
        end else if (apply) begin
            pend_v_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            act_q    <= DIV_RST;
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            z_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            act_q    <= act_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            z_q      <= z_d;
        end
    end

    assign Z    = z_q;
    assign BUSY = pend_v_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__clkdiv_prog.sv
// Scenario bench for the programmable clock divider.
// Expected Z/BUSY per cycle are queued when stimulus is driven.
module tb_gf180mcu_fd_sc_mcu7t5v0__clkdiv_prog;

    localparam int DIV_W = 4;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             EN = 1'b0;
    logic             LOAD = 1'b0;
    logic [DIV_W-1:0] DIV = '0;
    logic             Z;
    logic             BUSY;
    wire              vdd = 1'b1;
    wire              vss = 1'b0;

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [1:0] exp_q [$];

    gf180mcu_fd_sc_mcu7t5v0__clkdiv_prog dut (
        .CLK  (CLK),
        .RST  (RST),
        .EN   (EN),
        .LOAD (LOAD),
        .DIV  (DIV),
        .Z    (Z),
        .BUSY (BUSY),
        .VDD  (vdd),
        .VSS  (vss)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want summary");
        $fatal(1);
    end

    // Row layout: {rst, en, load, div[3:0], z_exp, busy_exp}
    function automatic logic [8:0] row(input logic r, input logic e,
                                       input logic ld, input logic [3:0] d,
                                       input logic [1:0] x);
        return {r, e, ld, d, x};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [8:0] r);
        RST  = r[8];
        EN   = r[7];
        LOAD = r[6];
        DIV  = r[5:2];
        exp_q.push_back(r[1:0]);
    endtask

    task automatic test_reset();
        logic [8:0] rows [$];
        logic [1:0] e;
        for (int i = 0; i < 2; i++) rows.push_back(row(1, 1, 0, 0, 2'b00));
        for (int i = 0; i < 8; i++)
            rows.push_back(row(0, 1, 0, 0, (i % 2 == 0) ? 2'b10 : 2'b00));
        foreach (rows[i]) begin
            drive(rows[i]);
            tick();
            e = exp_q.pop_front();
            total_cnt++;
            if ({Z, BUSY} !== e)
                $display("FAIL reset_ratio2 cyc%0d: got Z,BUSY=%b want %b", i, {Z, BUSY}, e);
            else
                pass_cnt++;
        end
    endtask

    task automatic test_reload();
        logic [8:0] rows [$];
        logic [1:0] e;
        rows.push_back(row(0, 1, 0, 0, 2'b10));
        rows.push_back(row(0, 1, 1, 2, 2'b01));
        for (int i = 0; i < 3; i++) rows.push_back(row(0, 1, 0, 0, 2'b10));
        for (int i = 0; i < 3; i++) rows.push_back(row(0, 1, 0, 0, 2'b00));
        rows.push_back(row(0, 1, 0, 0, 2'b10));
        foreach (rows[i]) begin
            drive(rows[i]);
            tick();
            e = exp_q.pop_front();
            total_cnt++;
            if ({Z, BUSY} !== e)
                $display("FAIL reload_div2 cyc%0d: got Z,BUSY=%b want %b", i, {Z, BUSY}, e);
            else
                pass_cnt++;
        end
    endtask

    task automatic test_en_drop();
        logic [8:0] rows [$];
        logic [1:0] e;
        rows.push_back(row(0, 1, 0, 0, 2'b10));
        rows.push_back(row(0, 0, 0, 0, 2'b10));
        for (int i = 0; i < 6; i++) rows.push_back(row(0, 0, 0, 0, 2'b00));
        foreach (rows[i]) begin
            drive(rows[i]);
            tick();
            e = exp_q.pop_front();
            total_cnt++;
            if ({Z, BUSY} !== e)
                $display("FAIL en_drop cyc%0d: got Z,BUSY=%b want %b", i, {Z, BUSY}, e);
            else
                pass_cnt++;
        end
    endtask

    task automatic test_back_to_back_loads();
        logic [8:0] rows [$];
        logic [1:0] e;
        rows.push_back(row(0, 1, 0, 0, 2'b10));
        rows.push_back(row(0, 1, 1, 3, 2'b11));
        rows.push_back(row(0, 1, 0, 0, 2'b11));
        rows.push_back(row(0, 1, 1, 5, 2'b01));
        rows.push_back(row(0, 1, 0, 0, 2'b01));
        rows.push_back(row(0, 1, 0, 0, 2'b01));
        rows.push_back(row(0, 1, 0, 0, 2'b10));
        for (int i = 0; i < 5; i++) rows.push_back(row(0, 0, 0, 0, 2'b10));
        for (int i = 0; i < 8; i++) rows.push_back(row(0, 0, 0, 0, 2'b00));
        foreach (rows[i]) begin
            drive(rows[i]);
            tick();
            e = exp_q.pop_front();
            total_cnt++;
            if ({Z, BUSY} !== e)
                $display("FAIL two_loads cyc%0d: got Z,BUSY=%b want %b", i, {Z, BUSY}, e);
            else
                pass_cnt++;
        end
    endtask

    task automatic test_reset_mid();
        logic [8:0] rows [$];
        logic [1:0] e;
        rows.push_back(row(0, 1, 0, 0, 2'b10));
        rows.push_back(row(0, 1, 1, 1, 2'b11));
        rows.push_back(row(1, 1, 0, 0, 2'b00));
        for (int i = 0; i < 4; i++)
            rows.push_back(row(0, 1, 0, 0, (i % 2 == 0) ? 2'b10 : 2'b00));
        foreach (rows[i]) begin
            drive(rows[i]);
            tick();
            e = exp_q.pop_front();
            total_cnt++;
            if ({Z, BUSY} !== e)
                $display("FAIL reset_mid cyc%0d: got Z,BUSY=%b want %b", i, {Z, BUSY}, e);
            else
                pass_cnt++;
        end
    endtask

    task automatic test_odd();
        logic [8:0] rows [$];
        logic [1:0] e;
        rows.push_back(row(1, 0, 0, 0, 2'b00));
        rows.push_back(row(0, 0, 1, 1, 2'b01));
        for (int i = 0; i < 9; i++)
            rows.push_back(row(0, 1, 0, 0, (i % 3 == 2) ? 2'b00 : 2'b10));
        foreach (rows[i]) begin
            drive(rows[i]);
            tick();
            e = exp_q.pop_front();
            total_cnt++;
            if ({Z, BUSY} !== e)
                $display("FAIL odd_ratio3 cyc%0d: got Z,BUSY=%b want %b", i, {Z, BUSY}, e);
            else
                pass_cnt++;
        end
    endtask

    initial begin
        @(negedge CLK);
        test_reset();
`ifdef GF180MCU_CLKDIV_ODD_EN
        test_odd();
`else
        test_reload();
        test_en_drop();
        test_back_to_back_loads();
        test_reset_mid();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
